pe_inst_seq: RTL and testbench

//  Instruction sequencer directly upstream of the PE data memory/register file.

---
 rtl/pe_inst_seq_pkg.sv | 24 ++
 rtl/pe_inst_seq_if.sv | 25 ++
 rtl/pe_inst_seq_inst_buf.sv | 29 ++
 rtl/pe_inst_seq.sv | 129 ++++++++++++
 tb/tb_pe_inst_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_inst_seq_pkg.sv
// Shared constants and types for the PE instruction sequencer.
// Instruction layout: raddr0[7:0], raddr1[15:8], waddr[23:16], write-back flag in the MSB.
package pe_inst_seq_pkg;

    localparam int INST_WIDTH    = 32;
    localparam int DM_ADDR_WIDTH = 8;
    localparam int WB_BIT        = INST_WIDTH - 1;
    localparam int RADDR0_LSB    = 0;
    localparam int RADDR1_LSB    = 8;
    localparam int WADDR_LSB     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } seq_state_e;

    function automatic logic inst_wb(input logic [INST_WIDTH-1:0] word);
        return word[WB_BIT];
    endfunction

endpackage

// File: rtl/pe_inst_seq_if.sv
// Program-load stream from the array controller into the instruction sequencer.
// The controller is the master; the sequencer is the slave and returns inst_in_rdy.
interface pe_inst_seq_if;
    import pe_inst_seq_pkg::*;

    logic                  inst_in_v;
    logic [INST_WIDTH-1:0] inst_in;
    logic                  inst_in_last;
    logic                  inst_in_rdy;

    modport master (
        output inst_in_v,
        output inst_in,
        output inst_in_last,
        input  inst_in_rdy
    );

    modport slave (
        input  inst_in_v,
        input  inst_in,
        input  inst_in_last,
        output inst_in_rdy
    );

endinterface

// File: rtl/pe_inst_seq_inst_buf.sv
// Program buffer: one write port, one synchronous read port with read enable.
// The read register only updates on an issue, so it doubles as the held inst output.
module seq_inst_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    (* ram_style = "distributed" *) logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pe_inst_seq.sv
// PE instruction sequencer: buffers a streamed program and replays it loop_cnt+1 times.
// Optional stall_cycles performance counter is enabled with macro SEQ_PERF_EN.
module pe_inst_seq
    import pe_inst_seq_pkg::*;
#(
    parameter int IM_DEPTH = 16,
    parameter int IM_AW    = 4,
    parameter int LOOP_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_inst_seq_if.slave          prog,
    input  logic                  start,
    input  logic [LOOP_W-1:0]     loop_cnt,
    input  logic                  stall,
    output logic                  inst_v,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  rden,
    output logic                  wren,
    output logic                  busy,
    output logic                  done
`ifdef SEQ_PERF_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam logic [IM_AW:0] DEPTH_CNT = (IM_AW + 1)'(IM_DEPTH);

    seq_state_e            state, state_nx;
    logic [IM_AW:0]        wr_cnt, wr_cnt_nx, prog_len;
    logic [IM_AW-1:0]      pc, wr_addr;
    logic [LOOP_W-1:0]     pass, loop_q;
    logic                  accept, load_end, start_ok;
    logic                  issue, last_pc, final_issue;
    logic                  inst_v_q;
    logic [INST_WIDTH-1:0] rd_data;

    assign prog.inst_in_rdy = (state inside {S_IDLE, S_LOAD, S_READY}) && (wr_cnt < DEPTH_CNT);

    always_comb begin
        state_nx    = state;
        accept      = prog.inst_in_v && prog.inst_in_rdy;
        // A word accepted outside LOAD starts a fresh program at address 0.
        wr_cnt_nx   = (state == S_LOAD) ? wr_cnt + 1'b1 : (IM_AW + 1)'(1);
        wr_addr     = (state == S_LOAD) ? wr_cnt[IM_AW-1:0] : '0;
        load_end    = accept && (prog.inst_in_last || (wr_cnt_nx == DEPTH_CNT));
        start_ok    = (state == S_READY) && start && !accept;
        issue       = (state == S_RUN) && !stall;
        last_pc     = ({1'b0, pc} == (prog_len - 1'b1));
        final_issue = issue && last_pc && (pass == loop_q);

        unique case (state)
            S_IDLE, S_READY: begin
                if (accept)        state_nx = load_end ? S_READY : S_LOAD;
                else if (start_ok) state_nx = S_RUN;
            end
            S_LOAD:  if (load_end) state_nx = S_READY;
            S_RUN:   if (final_issue) state_nx = S_DONE;
            S_DONE:  state_nx = S_READY;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            prog_len <= '0;
            pc       <= '0;
            pass     <= '0;
            loop_q   <= '0;
            inst_v_q <= 1'b0;
        end else begin
            inst_v_q <= issue;
            // wr_cnt is cleared on start so a finished replay can be followed by a reload.
            if (accept)        wr_cnt <= wr_cnt_nx;
            else if (start_ok) wr_cnt <= '0;
            if (load_end) prog_len <= wr_cnt_nx;
            if (start_ok) begin
                pc     <= '0;
                pass   <= '0;
                loop_q <= loop_cnt;
            end else if (issue) begin
                if (last_pc) begin
                    pc   <= '0;
                    pass <= pass + 1'b1;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    seq_inst_buf #(
        .DEPTH (IM_DEPTH),
        .AW    (IM_AW),
        .W     (INST_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (prog.inst_in),
        .re    (issue),
        .raddr (pc),
        .rdata (rd_data)
    );

    assign inst_v = inst_v_q;
    assign rden   = inst_v_q;
    assign inst   = rd_data;
    assign wren   = inst_v_q && inst_wb(rd_data);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

`ifdef SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              stall_cycles <= '0;
        else if (start_ok)                                    stall_cycles <= '0;
        else if ((state == S_RUN) && stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pe_inst_seq.sv
// Directed testbench for pe_inst_seq: table-driven load/replay vectors plus hand-written
// sequences for overflow, stalls, long loops and mid-run reset.
module tb_pe_inst_seq;
    import pe_inst_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        loop_cnt = '0;
    logic              stall = 1'b0;
    logic              inst_v, rden, wren, busy, done;
    logic [31:0]       inst;
`ifdef SEQ_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    pe_inst_seq_if prog ();

    pe_inst_seq #(
        .IM_DEPTH (16),
        .IM_AW    (4),
        .LOOP_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prog     (prog.slave),
        .start    (start),
        .loop_cnt (loop_cnt),
        .stall    (stall),
        .inst_v   (inst_v),
        .inst     (inst),
        .rden     (rden),
        .wren     (wren),
        .busy     (busy),
        .done     (done)
`ifdef SEQ_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        last;
        logic        st;
        logic [7:0]  lc;
        logic        e_rdy, e_v, e_wren, e_busy, e_done;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mkv(input logic v, input logic [31:0] w, input logic last,
                                 input logic st, input logic [7:0] lc,
                                 input logic e_rdy, input logic e_v, input logic e_wren,
                                 input logic e_busy, input logic e_done, input logic [31:0] e_inst);
        vec_t r;
        r.v = v; r.w = w; r.last = last; r.st = st; r.lc = lc;
        r.e_rdy = e_rdy; r.e_v = e_v; r.e_wren = e_wren;
        r.e_busy = e_busy; r.e_done = e_done; r.e_inst = e_inst;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive_word(input logic v, input logic [31:0] w, input logic last);
        prog.inst_in_v    = v;
        prog.inst_in      = w;
        prog.inst_in_last = last;
    endtask

    // Load exp_q as a program (last on final word); called at a negedge, returns at a negedge.
    task automatic load_prog();
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_word(1'b1, exp_q[i], i == exp_q.size() - 1);
            @(negedge clk);
        end
        drive_word(1'b0, '0, 1'b0);
    endtask

    task automatic do_start(input logic [7:0] lc);
        start = 1'b1;
        loop_cnt = lc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Watch a replay: counts issues, checks words against exp_q, measures inst_v gaps
    // and done alignment; optionally raises stall for stall_len cycles after stall_after issues.
    task automatic run_seq(input string name, input int budget, input int stall_after,
                           input int stall_len, input int exp_n, input int exp_gaps);
        int  n = 0, gaps = 0, stall_left = 0, done_at = -1, last_at = -2;
        bit  word_ok = 1, strobe_ok = 1, done_seen = 0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            @(negedge clk);
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end
            if (inst_v) begin
                if (inst !== exp_q[n % exp_q.size()]) word_ok = 0;
                if (rden !== 1'b1 || wren !== inst[31]) strobe_ok = 0;
                n++;
                last_at = c;
                if (n == stall_after && stall_len > 0) begin
                    stall = 1'b1;
                    stall_left = stall_len;
                end
            end else begin
                if (rden !== 1'b0 || wren !== 1'b0) strobe_ok = 0;
                if (n > 0) gaps++;
            end
            if (done) begin
                done_seen = 1;
                done_at = c;
            end
        end
        stall = 1'b0;
        check({name, "_issues"}, 64'(n), 64'(exp_n));
        check({name, "_words"}, 64'(word_ok), 64'd1);
        check({name, "_strobes"}, 64'(strobe_ok), 64'd1);
        check({name, "_gaps"}, 64'(gaps), 64'(exp_gaps));
        check({name, "_done_align"}, 64'(done_at), 64'(last_at));
        @(negedge clk);
        check({name, "_after"}, {61'd0, busy, done, inst_v}, 64'd0);
    endtask

    localparam logic [31:0] WA = 32'h0003_0201;
    localparam logic [31:0] WB = 32'h8006_0504;
    localparam logic [31:0] WC = 32'h0009_0807;

    initial begin
        logic [31:0] w;
        bit quiet;
        drive_word(1'b0, '0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out", {26'd0, inst_v, rden, wren, busy, done, inst}, 64'd0);
        rst = 1'b0;
        check("reset_rdy", 64'(prog.inst_in_rdy), 64'd1);

        // Test 1 and start-ignored cases: A,B(WB),C with loop_cnt=1
        tbl.push_back(mkv(0, '0, 0, 1, 8'd0, 1, 0, 0, 0, 0, '0)); // start in IDLE
        tbl.push_back(mkv(1, WA, 0, 0, 8'd0, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mkv(1, WB, 0, 0, 8'd0, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mkv(1, WC, 1, 0, 8'd0, 1, 0, 0, 0, 0, '0));
        tbl.push_back(mkv(0, '0, 0, 1, 8'd1, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 0, 1, 0, 1, 0, WA));
        tbl.push_back(mkv(0, '0, 0, 1, 8'd5, 0, 1, 1, 1, 0, WB)); // start during RUN
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 0, 1, 0, 1, 0, WC));
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 0, 1, 0, 1, 0, WA));
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 0, 1, 1, 1, 0, WB));
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 0, 1, 0, 0, 1, WC));
        tbl.push_back(mkv(0, '0, 0, 0, 8'd0, 1, 0, 0, 0, 0, WC));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_word(tbl[i].v, tbl[i].w, tbl[i].last);
            start = tbl[i].st;
            loop_cnt = tbl[i].lc;
            @(negedge clk);
            check($sformatf("t1_row%0d", i),
                  {26'd0, prog.inst_in_rdy, inst_v, rden, wren, busy, done, inst},
                  {26'd0, tbl[i].e_rdy, tbl[i].e_v, tbl[i].e_v, tbl[i].e_wren,
                   tbl[i].e_busy, tbl[i].e_done, tbl[i].e_inst});
        end
        drive_word(1'b0, '0, 1'b0);
        start = 1'b0;

        // Test 2: 17 words without last, only 16 accepted
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            w = 32'h1000_0000 + 32'(i);
            if (i % 2 == 1) w[31] = 1'b1;
            if (i < 16) exp_q.push_back(w);
            drive_word(1'b1, w, 1'b0);
            #1;
            if (i == 15 || i == 16) check($sformatf("t2_rdy%0d", i), 64'(prog.inst_in_rdy), 64'(i < 16));
            @(negedge clk);
        end
        drive_word(1'b0, '0, 1'b0);
        check("t2_ready", {62'd0, busy, prog.inst_in_rdy}, 64'd0);
        do_start(8'd0);
        run_seq("t2", 40, 0, 0, 16, 0);

        // Test 3: 4 words, 2-cycle stall after the 2nd issue
        exp_q = '{32'h0000_0110, 32'h8000_0220, 32'h0000_0330, 32'h0000_0440};
        load_prog();
        do_start(8'd0);
        run_seq("t3", 30, 2, 2, 4, 2);
`ifdef SEQ_PERF_EN
        check("t3_stall_cycles", 64'(stall_cycles), 64'd2);
`endif

        // Test 6: reload in READY with one word, 256 passes
        exp_q = '{32'h8123_4567};
        load_prog();
        do_start(8'd255);
        run_seq("t6", 300, 0, 0, 256, 0);
`ifdef SEQ_PERF_EN
        check("t6_stall_cycles", 64'(stall_cycles), 64'd0);
`endif

        // Test 5: reset mid-RUN, then start without reload
        exp_q = '{WA, WB, WC};
        load_prog();
        do_start(8'd3);
        repeat (4) @(negedge clk);
        check("t5_running", {62'd0, busy, inst_v}, 64'd3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_out", {26'd0, inst_v, rden, wren, busy, done, inst}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || inst_v || busy) quiet = 0;
        end
        check("t5_no_done", 64'(quiet), 64'd1);
        do_start(8'd0);
        quiet = 1;
        for (int c = 0; c < 10; c++) begin
            if (done || inst_v || busy) quiet = 0;
            @(negedge clk);
        end
        check("t5_start_ignored", 64'(quiet), 64'd1);
        check("t5_idle_rdy", 64'(prog.inst_in_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
